bubble_sort_top: RTL and testbench

// - Fully pipelined parallel sorter (odd-even transposition / bubble network) for input_num unsigned 8-bit keys.
// - Accepts one packed vector per clock and emits it sorted ascending after a fixed latency.
// - A 1-bit sideband tag (cks) travels alongside each vector with identical latency.
// - Sits in the datapath as a free-running, no-backpressure sort stage.

---
 rtl/bubble_sort_top.sv | 57 +++++
 tb/tb_bubble_sort_top.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bubble_sort_top.sv
// Pipelined odd-even transposition sorter: one packed vector of input_num unsigned
// 8-bit keys per clock, sorted ascending (lane 0 smallest) after input_num cycles.
module bubble_sort_top #(
  parameter int input_num = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*input_num-1:0] data_in,
  input  logic                   cks_in,
  output logic [8*input_num-1:0] data_out,
  output logic                   cks_out
);

  logic [input_num-1:0][7:0] w_stage_in  [input_num];
  logic [input_num-1:0][7:0] w_stage_out [input_num];
  logic [input_num-1:0][7:0] r_stage     [input_num];
  logic [input_num-1:0]      r_cks;

  for (genvar s = 0; s < input_num; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_stage_in[s] = data_in;
    end else begin : g_chain
      assign w_stage_in[s] = r_stage[s-1];
    end

    // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..; strict > keeps equal keys in place
    for (genvar l = 0; l < input_num; l++) begin : g_lane
      if (((l % 2) == (s % 2)) && (l + 1 < input_num)) begin : g_lo
        assign w_stage_out[s][l] = (w_stage_in[s][l] > w_stage_in[s][l+1]) ?
                                   w_stage_in[s][l+1] : w_stage_in[s][l];
      end else if ((l >= 1) && (((l - 1) % 2) == (s % 2))) begin : g_hi
        assign w_stage_out[s][l] = (w_stage_in[s][l-1] > w_stage_in[s][l]) ?
                                   w_stage_in[s][l-1] : w_stage_in[s][l];
      end else begin : g_pass
        assign w_stage_out[s][l] = w_stage_in[s][l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < input_num; s++) begin
        r_stage[s] <= '0;
      end
      r_cks <= '0;
    end else begin
      for (int s = 0; s < input_num; s++) begin
        r_stage[s] <= w_stage_out[s];
      end
      r_cks <= {r_cks[input_num-2:0], cks_in};
    end
  end

  assign data_out = r_stage[input_num-1];
  assign cks_out  = r_cks[input_num-1];

endmodule

// File: tb/tb_bubble_sort_top.sv
// Directed and streaming checks of bubble_sort_top at input_num=8 and input_num=3,
// including a mid-stream reset; expected vectors come from hand values or a bench sort.
module tb_bubble_sort_top;

  localparam int NIT   = 1020;
  localparam int RST_M = 507;

  logic        clk;
  logic        rst;
  logic [63:0] data_in8, data_out8;
  logic [23:0] data_in3, data_out3;
  logic        cks_in8, cks_out8, cks_in3, cks_out3;

  logic [63:0] in8  [NIT];
  logic [63:0] exp8 [NIT];
  logic [23:0] in3  [NIT];
  logic [23:0] exp3 [NIT];
  logic        c8   [NIT];
  logic        c3   [NIT];
  logic        rn   [NIT];

  int n_checks = 0;
  int n_fail   = 0;

  bubble_sort_top #(.input_num(8)) u_dut8 (
    .clk(clk), .rst(rst), .data_in(data_in8), .cks_in(cks_in8),
    .data_out(data_out8), .cks_out(cks_out8)
  );

  bubble_sort_top #(.input_num(3)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(data_in3), .cks_in(cks_in3),
    .data_out(data_out3), .cks_out(cks_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Insertion sort over the low n byte lanes, ascending from lane 0
  function automatic logic [63:0] sort_vec(input logic [63:0] v, input int n);
    logic [7:0] k [8];
    logic [7:0] t;
    logic [63:0] r;
    int j;
    for (int i = 0; i < 8; i++) k[i] = v[8*i +: 8];
    for (int i = 1; i < n; i++) begin
      t = k[i];
      j = i - 1;
      while (j >= 0 && k[j] > t) begin
        k[j+1] = k[j];
        j--;
      end
      k[j+1] = t;
    end
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = k[i];
    return r;
  endfunction

  initial begin
    logic [63:0] tmp;
    int last_rst;
    int src;

    rst = 1'b0; data_in8 = '0; data_in3 = '0; cks_in8 = 1'b0; cks_in3 = 1'b0;

    for (int j = 0; j < NIT; j++) begin
      rn[j]  = !(j < 2 || j == RST_M);
      in8[j] = {$urandom, $urandom};
      tmp    = {32'b0, $urandom};
      in3[j] = tmp[23:0];
      c8[j]  = 1'($urandom_range(0, 1));
      c3[j]  = 1'($urandom_range(0, 1));
      exp8[j] = sort_vec(in8[j], 8);
      tmp     = sort_vec({40'b0, in3[j]}, 3);
      exp3[j] = tmp[23:0];
    end

    // Hand-computed directed vectors
    in8[2] = 64'hB963E10727147437; exp8[2] = 64'hE1B9746337271407; c8[2] = 1'b1;
    in3[2] = 24'hB963E1;           exp3[2] = 24'hE1B963;           c3[2] = 1'b0;
    in8[3] = 64'h0001020304050607; exp8[3] = 64'h0706050403020100;
    in8[4] = 64'h0706050403020100; exp8[4] = 64'h0706050403020100;
    in8[5] = 64'hFFFFFFFFFFFFFFFF; exp8[5] = 64'hFFFFFFFFFFFFFFFF;
    in8[6] = 64'h05050000FFFF0909; exp8[6] = 64'hFFFF090905050000;

    last_rst = -1;
    for (int j = 0; j < NIT; j++) begin
      @(negedge clk);
      src = j - 8;
      if (src < 0 || last_rst >= src) begin
        check($sformatf("data8@%0d", j), data_out8, 64'h0);
        check($sformatf("cks8@%0d", j), {63'b0, cks_out8}, 64'h0);
      end else begin
        check($sformatf("data8@%0d", j), data_out8, exp8[src]);
        check($sformatf("cks8@%0d", j), {63'b0, cks_out8}, {63'b0, c8[src]});
      end
      src = j - 3;
      if (src < 0 || last_rst >= src) begin
        check($sformatf("data3@%0d", j), {40'b0, data_out3}, 64'h0);
        check($sformatf("cks3@%0d", j), {63'b0, cks_out3}, 64'h0);
      end else begin
        check($sformatf("data3@%0d", j), {40'b0, data_out3}, {40'b0, exp3[src]});
        check($sformatf("cks3@%0d", j), {63'b0, cks_out3}, {63'b0, c3[src]});
      end
      rst      = rn[j];
      data_in8 = in8[j];
      data_in3 = in3[j];
      cks_in8  = c8[j];
      cks_in3  = c3[j];
      if (!rn[j]) last_rst = j;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
